// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - shared types and parity helper for the convolutional encoder
package conv_enc_pkg;

    // Widest shift window the parity helper handles; narrower windows are zero-extended.
    localparam int MAX_N = 64;

    typedef enum logic {
        ST_DATA,
        ST_TAIL
    } conv_state_t;

    function automatic logic parity(input logic [MAX_N-1:0] mask,
                                    input logic [MAX_N-1:0] window);
        return ^(mask & window);
    endfunction

endpackage

// File: rtl/conv_parity.sv
// rtl/conv_parity.sv - parity of one generator mask against the current shift window
module conv_parity
    import conv_enc_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0] g,
    input  logic [N-1:0] w,
    output logic         p
);

    logic [MAX_N-1:0] g_ext;
    logic [MAX_N-1:0] w_ext;

    always_comb begin
        g_ext        = '0;
        w_ext        = '0;
        g_ext[N-1:0] = g;
        w_ext[N-1:0] = w;
    end

    assign p = parity(g_ext, w_ext);

endmodule

// File: rtl/conv_enc_stream.sv
// rtl/conv_enc_stream.sv - rate-1/R convolutional encoder with streaming I/O and zero-tail termination
module conv_enc_stream
    import conv_enc_pkg::*;
#(
    parameter int N = 6,
    parameter int R = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mask_we,
    input  logic [$clog2(R)-1:0] mask_sel,
    input  logic [N-1:0]         mask,
    input  logic                 tail_en,
    input  logic                 in_valid,
    input  logic                 in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [R-1:0]         out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int SW = $clog2(R);
    localparam int TW = $clog2(N);

    conv_state_t  state;
    logic [TW-1:0] tail_cnt;
    logic [N-1:0] sr;
    logic [N-1:0] g [R];

    logic         can_load;
    logic         step;
    logic         bit_in;
    logic [N-1:0] w;
    logic [R-1:0] par;

    // The output register can take a new symbol when empty or being drained this cycle.
    assign can_load = !out_valid || out_ready;
    assign in_ready = (state == ST_DATA) && can_load;
    assign step     = (state == ST_DATA) ? (in_valid && in_ready) : can_load;
    assign bit_in   = (state == ST_DATA) ? in_data : 1'b0;
    assign w        = {bit_in, sr[N-1:1]};
    assign busy     = (state == ST_TAIL);

    for (genvar gi = 0; gi < R; gi++) begin : g_par
        conv_parity #(.N(N)) u_parity (
            .g (g[gi]),
            .w (w),
            .p (par[gi])
        );
    end

    // Out-of-range selects match no index and are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < R; r++) begin
                g[r] <= '0;
            end
        end else if (mask_we) begin
            for (int r = 0; r < R; r++) begin
                if (mask_sel == SW'(r)) begin
                    g[r] <= mask;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_DATA;
            tail_cnt  <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (step) begin
            sr        <= w;
            out_valid <= 1'b1;
            out_data  <= par;
            case (state)
                ST_DATA: begin
                    if (in_last && tail_en) begin
                        state    <= ST_TAIL;
                        tail_cnt <= TW'(N - 1);
                        out_last <= 1'b0;
                    end else begin
                        out_last <= in_last;
                    end
                end
                ST_TAIL: begin
                    tail_cnt <= tail_cnt - TW'(1);
                    out_last <= (tail_cnt == TW'(1));
                    if (tail_cnt == TW'(1)) begin
                        state <= ST_DATA;
                    end
                end
                default: state <= ST_DATA;
            endcase
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_enc_stream.sv
// tb/tb_conv_enc_stream.sv - scoreboard bench for conv_enc_stream at (N=3,R=2) and (N=7,R=3)
module tb_conv_enc_stream;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       a_mask_we, a_mask_sel, a_tail_en, a_in_valid, a_in_data, a_in_last;
    logic [2:0] a_mask;
    logic       a_in_ready, a_out_valid, a_out_last, a_out_ready, a_busy;
    logic [1:0] a_out_data;

    logic       b_mask_we, b_tail_en, b_in_valid, b_in_data, b_in_last;
    logic [1:0] b_mask_sel;
    logic [6:0] b_mask;
    logic       b_in_ready, b_out_valid, b_out_last, b_out_ready, b_busy;
    logic [2:0] b_out_data;

    conv_enc_stream #(.N(3), .R(2)) u_dut_a (
        .clk(clk), .reset(reset), .mask_we(a_mask_we), .mask_sel(a_mask_sel), .mask(a_mask),
        .tail_en(a_tail_en), .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_last(a_out_last), .out_ready(a_out_ready), .busy(a_busy)
    );

    conv_enc_stream #(.N(7), .R(3)) u_dut_b (
        .clk(clk), .reset(reset), .mask_we(b_mask_we), .mask_sel(b_mask_sel), .mask(b_mask),
        .tail_en(b_tail_en), .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_last(b_out_last), .out_ready(b_out_ready), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference models: scoreboard queues hold {last, data}.
    logic [2:0] a_sr;
    logic [2:0] a_g [2];
    logic [2:0] a_q [$];
    logic [2:0] a_log [$];
    int         a_cnt = 0;
    logic       a_bp = 1'b0;

    logic [6:0] b_sr;
    logic [6:0] b_g [3];
    logic [3:0] b_q [$];
    int         b_cnt = 0;

    task automatic a_step(input logic b, input logic lst);
        logic [2:0] w;
        logic [1:0] d;
        w = {b, a_sr[2:1]};
        for (int r = 0; r < 2; r++) d[r] = ^(a_g[r] & w);
        a_sr = w;
        a_q.push_back({lst, d});
    endtask

    task automatic b_step(input logic b, input logic lst);
        logic [6:0] w;
        logic [2:0] d;
        w = {b, b_sr[6:1]};
        for (int r = 0; r < 3; r++) d[r] = ^(b_g[r] & w);
        b_sr = w;
        b_q.push_back({lst, d});
    endtask

    task automatic a_send(input logic b, input logic lst, input logic te);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_data  = b;
        a_in_last  = lst;
        a_tail_en  = te;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_accept", a_in_ready, 1);
        a_step(b, lst && !te);
        if (lst && te) for (int i = 0; i < 2; i++) a_step(1'b0, i == 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic b, input logic lst);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_data  = b;
        b_in_last  = lst;
        b_tail_en  = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_accept", b_in_ready, 1);
        b_step(b, 1'b0);
        if (lst) for (int i = 0; i < 6; i++) b_step(1'b0, i == 5);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic a_wr(input logic sel, input logic [2:0] val);
        a_mask_we  = 1'b1;
        a_mask_sel = sel;
        a_mask     = val;
        @(posedge clk);
        #1;
        a_mask_we  = 1'b0;
        a_g[sel]   = val;
    endtask

    task automatic b_wr(input logic [1:0] sel, input logic [6:0] val);
        b_mask_we  = 1'b1;
        b_mask_sel = sel;
        b_mask     = val;
        @(posedge clk);
        #1;
        b_mask_we  = 1'b0;
        b_g[sel]   = val;
    endtask

    task automatic a_drain();
        int n = 0;
        while ((a_q.size() != 0 || a_out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("a_drain", a_q.size(), 0);
    endtask

    task automatic a_ref_frame();
        a_send(1'b1, 1'b0, 1'b1);
        a_send(1'b0, 1'b0, 1'b1);
        a_send(1'b1, 1'b0, 1'b1);
        a_send(1'b1, 1'b1, 1'b1);
    endtask

    task automatic a_check_log(input string tag);
        logic [2:0] ref_tab [6];
        ref_tab = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};
        check({tag, "_len"}, a_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < a_log.size()) check($sformatf("%s_sym%0d", tag, i), a_log[i], ref_tab[i]);
        end
    endtask

    // Compare the held symbol every cycle it is valid; pop only when it is taken.
    always @(negedge clk) begin
        if (reset && a_out_valid) begin
            if (a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got symbol 0x%0h expected none", {a_out_last, a_out_data});
            end else begin
                check("a_sym", {a_out_last, a_out_data}, a_q[0]);
                if (a_out_ready) begin
                    a_log.push_back({a_out_last, a_out_data});
                    void'(a_q.pop_front());
                    a_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && b_out_valid) begin
            if (b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got symbol 0x%0h expected none", {b_out_last, b_out_data});
            end else begin
                check("b_sym", {b_out_last, b_out_data}, b_q[0]);
                if (b_out_ready) begin
                    void'(b_q.pop_front());
                    b_cnt++;
                end
            end
        end
    end

    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_out_ready = a_bp ? ~a_out_ready : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        a_mask_we = 0; a_mask_sel = 0; a_mask = '0; a_tail_en = 0;
        a_in_valid = 0; a_in_data = 0; a_in_last = 0;
        b_mask_we = 0; b_mask_sel = '0; b_mask = '0; b_tail_en = 0;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1'b1;
        a_sr = '0; a_g[0] = '0; a_g[1] = '0;
        b_sr = '0; for (int r = 0; r < 3; r++) b_g[r] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        a_wr(1'b0, 3'b111);
        a_wr(1'b1, 3'b101);

        // (7,5) reference frame with zero tail
        a_log.delete();
        a_ref_frame();
        check("ref_tail_ready0", a_in_ready, 0);
        check("ref_tail_busy", a_busy, 1);
        @(posedge clk);
        #1;
        check("ref_tail_ready1", a_in_ready, 0);
        @(posedge clk);
        #1;
        check("ref_tail_ready2", a_in_ready, 1);
        check("ref_tail_busy_done", a_busy, 0);
        a_drain();
        a_check_log("ref");

        // Same frame with out_ready toggling
        a_bp = 1'b1;
        a_log.delete();
        a_ref_frame();
        a_drain();
        a_bp = 1'b0;
        a_check_log("bp");

        // Streaming frames without tail; state carries across frames
        base = a_cnt;
        a_send(1'b1, 1'b0, 1'b0);
        a_send(1'b1, 1'b1, 1'b0);
        a_send(1'b0, 1'b0, 1'b0);
        a_send(1'b1, 1'b1, 1'b0);
        check("stream_busy", a_busy, 0);
        a_drain();
        check("stream_count", a_cnt - base, 4);

        // Mask write in the same cycle as bit 2 is accepted
        base = a_cnt;
        a_send(1'b1, 1'b0, 1'b1);
        a_mask_we = 1'b1; a_mask_sel = 1'b1; a_mask = 3'b011;
        a_send(1'b0, 1'b0, 1'b1);
        a_mask_we = 1'b0;
        a_g[1] = 3'b011;
        a_send(1'b1, 1'b0, 1'b1);
        a_send(1'b1, 1'b1, 1'b1);
        a_drain();
        check("live_mask_count", a_cnt - base, 6);

        // Generic N=7, R=3 with 64 random bits and tail
        b_wr(2'd0, 7'o133);
        b_wr(2'd1, 7'o171);
        b_wr(2'd2, 7'o165);
        for (int i = 0; i < 64; i++) b_send(1'($urandom_range(0, 1)), i == 63);
        n = 0;
        while ((b_q.size() != 0 || b_out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b_drain", b_q.size(), 0);
        check("b_symbol_count", b_cnt, 70);

        // Reset in the middle of the tail
        base = a_cnt;
        a_ref_frame();
        n = 0;
        while (a_cnt < base + 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_tail_reached", a_cnt - base, 5);
        reset = 1'b0;
        #1;
        check("abort_out_valid", a_out_valid, 0);
        check("abort_out_last", a_out_last, 0);
        check("abort_busy", a_busy, 0);
        a_q.delete();
        a_sr = '0; a_g[0] = '0; a_g[1] = '0;
        b_q.delete();
        b_sr = '0; for (int r = 0; r < 3; r++) b_g[r] = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", a_in_ready, 1);
        base = a_cnt;
        a_send(1'b1, 1'b1, 1'b0);
        a_send(1'b1, 1'b0, 1'b0);
        a_send(1'b0, 1'b1, 1'b0);
        a_drain();
        check("post_rst_count", a_cnt - base, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
